// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output.
// STREAM_MUX_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module stream_mux_rr #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned W = 4,
   localparam int unsigned SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   input  logic [N_CH-1:0]   ch_mask,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [SEL_W-1:0]  out_sel,
   input  logic              out_ready
);

   logic [N_CH-1:0]  req;
   logic             load;
   logic             xfer;
   logic [SEL_W-1:0] gnt;
   logic [W-1:0]     gnt_data;
   logic             out_valid_q;
   logic [W-1:0]     out_data_q;
   logic [SEL_W-1:0] out_sel_q;

   assign req  = in_valid & ch_mask;
   assign load = !out_valid_q || out_ready;
   // rst_n gates the handshake so nothing is accepted while reset is held.
   assign xfer = rst_n && load && (req != '0);

`ifdef STREAM_MUX_RR_EN
   logic [SEL_W-1:0] ptr_q;

   always_comb begin
      int unsigned idx;
      logic        found;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         // Explicit wrap instead of bit truncation keeps non-power-of-two counts correct.
         idx = 32'(ptr_q) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!found && req[idx]) begin
            gnt   = SEL_W'(idx);
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= SEL_W'(N_CH - 1);
      end else if (xfer) begin
         ptr_q <= gnt;
      end
   end
`else
   always_comb begin
      logic found;
      gnt   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && req[i]) begin
            gnt   = SEL_W'(i);
            found = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      gnt_data = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (gnt == SEL_W'(i)) gnt_data = in_data[i*W +: W];
      end
   end

   always_comb begin
      in_ready = '0;
      if (xfer) in_ready[gnt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else if (xfer) begin
         out_valid_q <= 1'b1;
         out_data_q  <= gnt_data;
         out_sel_q   <= gnt;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

endmodule
